// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four requesters feeding one WIDTH-bit valid/ready output stage.
// With BURST>1 a winner keeps the channel for up to BURST consecutive accepted beats.
module rr_mux_arbiter #(
    parameter int WIDTH = 4,
    parameter int BURST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       ack,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int BW = $clog2(BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_sel_q;
    logic [BW-1:0]    beats_q, beats_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             slot_free;
    logic             accept;
    logic             found;
    logic [1:0]       winner;
    logic [1:0]       idx;
    logic [WIDTH-1:0] mux_word;

    assign slot_free = !out_valid_q || out_ready;

    // First requester at or after ptr, scanning upward with wrap.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        beats_d = beats_q;
        accept  = 1'b0;
        sel     = last_sel_q;
        case (state_q)
            IDLE: begin
                if (found && slot_free) begin
                    accept = 1'b1;
                    sel    = winner;
                    if (BURST == 1) begin
                        ptr_d = winner + 2'd1;
                    end else begin
                        state_d = GRANT;
                        owner_d = winner;
                        beats_d = BW'(1);
                    end
                end
            end
            GRANT: begin
                sel = owner_q;
                if (req[owner_q]) begin
                    if (slot_free) begin
                        accept  = 1'b1;
                        beats_d = beats_q + BW'(1);
                        if (beats_q + BW'(1) == BW'(BURST)) begin
                            state_d = IDLE;
                            ptr_d   = owner_q + 2'd1;
                        end
                    end
                end else begin
                    // Owner dropped: release without taking a word this cycle.
                    state_d = IDLE;
                    ptr_d   = owner_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            accept = 1'b0;
        end
    end

    always_comb begin
        case (sel)
            2'd0:    mux_word = a;
            2'd1:    mux_word = b;
            2'd2:    mux_word = c;
            default: mux_word = d;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_word;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign ack       = accept ? (4'b0001 << sel) : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            last_sel_q  <= '0;
            beats_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            last_sel_q  <= sel;
            beats_q     <= beats_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: a BURST=1 and a BURST=3 instance share stimulus and are
// each compared against a grant/ownership reference model every cycle.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] a, b, c, d;
    logic             out_ready;

    logic [3:0]       ack_o   [2];
    logic [1:0]       sel_o   [2];
    logic             valid_o [2];
    logic [WIDTH-1:0] data_o  [2];

    int errors = 0;
    int checks = 0;

    // Reference model state per instance
    int               burst   [2] = '{1, 3};
    int               m_ptr   [2];
    int               m_owner [2];   // -1 when nobody holds the channel
    int               m_cnt   [2];
    logic             m_valid [2];
    logic [WIDTH-1:0] m_data  [2];

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(WIDTH), .BURST(1)) u_b1 (
        .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
        .ack(ack_o[0]), .sel(sel_o[0]), .out_valid(valid_o[0]),
        .out_ready(out_ready), .out_data(data_o[0])
    );

    rr_mux_arbiter #(.WIDTH(WIDTH), .BURST(3)) u_b3 (
        .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
        .ack(ack_o[1]), .sel(sel_o[1]), .out_valid(valid_o[1]),
        .out_ready(out_ready), .out_data(data_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k]   = 0;
            m_owner[k] = -1;
            m_cnt[k]   = 0;
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
        end
    endtask

    // One clock: drive inputs, check combinational ack/sel, clock, check output stage.
    task automatic step(input logic [3:0] r, input logic rdy);
        logic [WIDTH-1:0] words [4];
        logic             free;
        int               take;
        req       = r;
        out_ready = rdy;
        words     = '{a, b, c, d};
        #2;
        for (int k = 0; k < 2; k++) begin
            free = !m_valid[k] || rdy;
            take = -1;
            if (m_owner[k] >= 0) begin
                if (r[m_owner[k]]) begin
                    if (free) begin
                        take = m_owner[k];
                        m_cnt[k]++;
                        if (m_cnt[k] == burst[k]) begin
                            m_ptr[k]   = (m_owner[k] + 1) % 4;
                            m_owner[k] = -1;
                        end
                    end
                end else begin
                    m_ptr[k]   = (m_owner[k] + 1) % 4;
                    m_owner[k] = -1;
                end
            end else if (r != 4'b0000 && free) begin
                for (int j = 0; j < 4; j++)
                    if (take < 0 && r[(m_ptr[k] + j) % 4]) take = (m_ptr[k] + j) % 4;
                if (burst[k] == 1) m_ptr[k] = (take + 1) % 4;
                else begin
                    m_owner[k] = take;
                    m_cnt[k]   = 1;
                end
            end
            check($sformatf("ack[b%0d]", burst[k]), 32'(ack_o[k]),
                  take >= 0 ? 32'(1 << take) : 32'd0);
            if (take >= 0) begin
                check($sformatf("sel[b%0d]", burst[k]), 32'(sel_o[k]), 32'(take));
                m_valid[k] = 1'b1;
                m_data[k]  = words[take];
            end else if (rdy) begin
                m_valid[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("out_valid[b%0d]", burst[k]), 32'(valid_o[k]), 32'(m_valid[k]));
            check($sformatf("out_data[b%0d]", burst[k]), 32'(data_o[k]), 32'(m_data[k]));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] sweep_exp [5];
        sweep_exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};

        // Reset with all requesters active
        rst = 1'b1; req = 4'hF; out_ready = 1'b1;
        a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_ack", 32'(ack_o[k]), 32'd0);
            check("rst_valid", 32'(valid_o[k]), 32'd0);
            check("rst_data", 32'(data_o[k]), 32'd0);
        end
        rst = 1'b0;
        model_reset();
        #2;
        check("post_rst_sel", 32'(sel_o[0]), 32'd0);

        // Round-robin sweep (BURST=1 instance gives 1,2,3,4,1)
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 1'b1);
            check("sweep_data", 32'(data_o[0]), 32'(sweep_exp[i]));
        end

        // Backpressure: hold three cycles then release
        for (int i = 0; i < 3; i++) step(4'hF, 1'b0);
        step(4'hF, 1'b1);
        step(4'hF, 1'b1);

        // Wrap between requesters 0 and 3
        for (int i = 0; i < 6; i++) step(4'b1001, 1'b1);

        // Burst pattern with two requesters
        for (int i = 0; i < 12; i++) step(4'b0011, 1'b1);

        // Drop the owner mid-burst: realign so requester 0 wins, then release it
        step(4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0001, 1'b1);
        step(4'b0011, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);

        // Randomized traffic with occasional mid-operation reset
        for (int i = 0; i < 400; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            c = WIDTH'($urandom); d = WIDTH'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                req = 4'hF;
                #2;
                check("rst_mid_ack0", 32'(ack_o[0]), 32'd0);
                check("rst_mid_ack1", 32'(ack_o[1]), 32'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                model_reset();
                check("rst_mid_valid", 32'(valid_o[0]), 32'd0);
            end else begin
                step(4'($urandom), ($urandom_range(0, 3) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
